// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for 7-segment display blocks: the segment pattern type,
//   the all-segments-off pattern and the hex glyph table. Patterns are held in
//   active-low form, bit order {g,f,e,d,c,b,a}; any polarity change is applied
//   by the block that drives the pins.
// -----------------------------------------------------------------------------
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  // Active-low: every segment dark.
  localparam seg7_t SEG_OFF = 7'h7F;

  // Glyphs for 0..9, A, b, C, d, E, F.
  localparam seg7_t HEX_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage : seg7_pkg

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
//   Combinational hex nibble to 7-segment glyph lookup.
// Ports
//   i_nibble   in   4   hex value to display
//   o_pattern  out  7   active-low glyph {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg7_t      o_pattern
);

  assign o_pattern = HEX_TABLE[i_nibble];

endmodule : seg7_hex_decode

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed N-digit 7-segment driver. One digit is lit per scan slot;
//   each slot opens with a short all-anodes-off window to suppress ghosting.
//   Host writes land in a pending buffer that is copied to the displayed
//   buffer only at frame end, so a frame never mixes old and new data.
// Ports
//   iCLK    in   1             system clock
//   iRST_N  in   1             synchronous reset, active-low
//   iDATA   in   4*NUM_DIGITS  hex nibble per digit, digit k = iDATA[4k+3:4k]
//   iDP     in   NUM_DIGITS    decimal point on, per digit
//   iBLANK  in   NUM_DIGITS    force digit dark
//   iBLINK  in   NUM_DIGITS    digit dark during blink-off phase
//   iLOAD   in   1             capture iDATA/iDP/iBLANK/iBLINK into pending
//   oSEG    out  7             segments {g,f,e,d,c,b,a}
//   oDP     out  1             decimal point
//   oAN     out  NUM_DIGITS    digit enables
//   oFRAME  out  1             pulse on the last clock of the last digit
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYC    = 16,
  parameter int BLINK_FR    = 64,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic [NUM_DIGITS-1:0]   iDP,
  input  logic [NUM_DIGITS-1:0]   iBLANK,
  input  logic [NUM_DIGITS-1:0]   iBLINK,
  input  logic                    iLOAD,
  output logic [6:0]              oSEG,
  output logic                    oDP,
  output logic [NUM_DIGITS-1:0]   oAN,
  output logic                    oFRAME
);

  localparam int CW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FR > 1)   ? $clog2(BLINK_FR)   : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [DW-1:0] IDX_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FR - 1);

  // Internal patterns are active-low; these masks flip them for active-high pins.
  localparam seg7_t                 SEG_MASK = (SEG_ACT_LOW != 0) ? 7'h00 : 7'h7F;
  localparam logic                  DP_MASK  = (SEG_ACT_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic [NUM_DIGITS-1:0] AN_MASK  = (AN_ACT_LOW != 0) ? '0 : '1;

  // Scan and blink state
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_blink_off;

  // Pending (host-side) and active (displayed) buffers
  logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp,    r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank, r_act_blank;
  logic [NUM_DIGITS-1:0]   r_pend_blink, r_act_blink;

  // Registered pin drivers
  seg7_t                 r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  logic                    w_frame;
  logic                    w_slot_end;
  logic [4*NUM_DIGITS-1:0] w_pend_data;
  logic [NUM_DIGITS-1:0]   w_pend_dp, w_pend_blank, w_pend_blink;
  logic [3:0]              w_nibble;
  seg7_t                   w_glyph;
  logic                    w_dark;
  seg7_t                   w_seg_low;
  logic                    w_dp_low;
  logic [NUM_DIGITS-1:0]   w_an_low;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_frame    = w_slot_end && (r_idx == IDX_LAST);

  // A strobe on the frame-end clock must reach the active buffer in the same
  // clock, so the copy source is the post-strobe pending value.
  assign w_pend_data  = iLOAD ? iDATA  : r_pend_data;
  assign w_pend_dp    = iLOAD ? iDP    : r_pend_dp;
  assign w_pend_blank = iLOAD ? iBLANK : r_pend_blank;
  assign w_pend_blink = iLOAD ? iBLINK : r_pend_blink;

  assign w_nibble = 4'(r_act_data >> {r_idx, 2'b00});

  seg7_hex_decode u_decode (
    .i_nibble  (w_nibble),
    .o_pattern (w_glyph)
  );

  assign w_dark    = r_act_blank[r_idx] | (r_act_blink[r_idx] & r_blink_off);
  assign w_seg_low = w_dark ? SEG_OFF : w_glyph;
  assign w_dp_low  = w_dark | ~r_act_dp[r_idx];
  assign w_an_low  = (r_cnt < CNT_DEAD) ? '1 : ~(NUM_DIGITS'(1) << r_idx);

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_fcnt       <= '0;
      r_blink_off  <= 1'b0;
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_blink <= '0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
      r_act_blink  <= '0;
      r_seg        <= SEG_OFF ^ SEG_MASK;
      r_dp         <= 1'b1 ^ DP_MASK;
      r_an         <= '1 ^ AN_MASK;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      r_pend_data  <= w_pend_data;
      r_pend_dp    <= w_pend_dp;
      r_pend_blank <= w_pend_blank;
      r_pend_blink <= w_pend_blink;

      if (w_frame) begin
        r_act_data  <= w_pend_data;
        r_act_dp    <= w_pend_dp;
        r_act_blank <= w_pend_blank;
        r_act_blink <= w_pend_blink;
        r_fcnt      <= (r_fcnt == FR_LAST) ? '0 : r_fcnt + 1'b1;
        if (r_fcnt == FR_LAST) begin
          r_blink_off <= ~r_blink_off;
        end
      end

      r_seg <= w_seg_low ^ SEG_MASK;
      r_dp  <= w_dp_low ^ DP_MASK;
      r_an  <= w_an_low ^ AN_MASK;
    end
  end

  assign oSEG   = r_seg;
  assign oDP    = r_dp;
  assign oAN    = r_an;
  assign oFRAME = w_frame;

endmodule : seg7_scan_driver
